// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl
//   Double-buffered frame store for an LED matrix row scanner. The writer
//   fills the back bank row by row, requests a swap with i_commit, and the
//   swap happens on the next i_frame_end pulse from the scan side, so the
//   scanner never sees a half-updated frame. The back bank can also be
//   zeroed one row per cycle with i_clear.
//
// Parameters
//   NUM_ROWS        rows per frame
//   NUM_ROWS_WIDTH  row index width (2**NUM_ROWS_WIDTH >= NUM_ROWS)
//   NUM_COLS        bits per row
//
// Ports
//   clk          rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_wr_en      write one back-bank row
//   i_wr_row     row index for the write
//   i_wr_data    row data for the write
//   i_commit     request front/back swap at the next frame boundary
//   i_clear      request zeroing of the back bank
//   i_frame_end  end-of-scan pulse from the row scanner
//   o_frame      registered copy of the front bank
//   o_busy       high while a swap is pending or a clear is running
//   o_swap       one-cycle pulse after a swap
//   o_err        one-cycle pulse after a rejected write
module led_frame_ctrl #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [NUM_ROWS_WIDTH-1:0] i_wr_row,
    input  logic [NUM_COLS-1:0]       i_wr_data,
    input  logic                      i_commit,
    input  logic                      i_clear,
    input  logic                      i_frame_end,
    output logic [NUM_COLS-1:0]       o_frame [0:NUM_ROWS-1],
    output logic                      o_busy,
    output logic                      o_swap,
    output logic                      o_err
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        CLEARING
    } state_t;

    localparam logic [NUM_ROWS_WIDTH:0]   ROW_LIMIT = (NUM_ROWS_WIDTH + 1)'(NUM_ROWS);
    localparam logic [NUM_ROWS_WIDTH-1:0] LAST_ROW  = NUM_ROWS_WIDTH'(NUM_ROWS - 1);

    state_t                    state;
    logic [NUM_COLS-1:0]       bank [0:1][0:NUM_ROWS-1];
    logic                      front_sel;
    logic                      back_sel;
    logic [NUM_ROWS_WIDTH-1:0] clr_row;
    logic                      row_ok;

    always_comb begin
        back_sel = ~front_sel;
        // Extra bit lets the comparison see NUM_ROWS itself when it is a power of two.
        row_ok   = {1'b0, i_wr_row} < ROW_LIMIT;
    end

    // o_frame is only ever loaded at a swap: the front bank is never written
    // outside reset, so the copy cannot go stale between swaps.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            bank      <= '{default: '0};
            front_sel <= 1'b0;
            clr_row   <= '0;
            o_frame   <= '{default: '0};
            o_busy    <= 1'b0;
            o_swap    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_swap <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear wins over commit and any write in the same cycle.
                    if (i_clear) begin
                        state   <= CLEARING;
                        clr_row <= '0;
                        o_busy  <= 1'b1;
                    end else begin
                        if (i_wr_en) begin
                            if (row_ok) begin
                                bank[back_sel][i_wr_row] <= i_wr_data;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                        // A frame_end coinciding with the commit is not
                        // seen here; the swap waits for the next one.
                        if (i_commit) begin
                            state  <= PENDING;
                            o_busy <= 1'b1;
                        end
                    end
                end

                PENDING: begin
                    o_err <= i_wr_en;
                    if (i_frame_end) begin
                        front_sel <= back_sel;
                        o_frame   <= bank[back_sel];
                        o_swap    <= 1'b1;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                    end
                end

                CLEARING: begin
                    o_err <= i_wr_en;
                    bank[back_sel][clr_row] <= '0;
                    if (clr_row == LAST_ROW) begin
                        clr_row <= '0;
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        clr_row <= clr_row + NUM_ROWS_WIDTH'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// tb_led_frame_ctrl
//   Self-checking bench for led_frame_ctrl. The main instance uses 4x8;
//   a second 3-row instance exercises the out-of-range write index.
//   Expected frames are pushed to a scoreboard queue at commit time and
//   popped when the DUT pulses o_swap.
module tb_led_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       i_rst;
    logic       i_wr_en;
    logic [1:0] i_wr_row;
    logic [7:0] i_wr_data;
    logic       i_commit;
    logic       i_clear;
    logic       i_frame_end;
    logic [7:0] o_frame [0:3];
    logic       o_busy;
    logic       o_swap;
    logic       o_err;

    logic       b_wr_en;
    logic [1:0] b_wr_row;
    logic [7:0] b_wr_data;
    logic       b_commit;
    logic       b_clear;
    logic       b_frame_end;
    logic [7:0] b_frame [0:2];
    logic       b_busy;
    logic       b_swap;
    logic       b_err;

    led_frame_ctrl #(.NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(8)) dut (
        .clk(clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_row(i_wr_row),
        .i_wr_data(i_wr_data), .i_commit(i_commit), .i_clear(i_clear),
        .i_frame_end(i_frame_end), .o_frame(o_frame), .o_busy(o_busy),
        .o_swap(o_swap), .o_err(o_err)
    );

    led_frame_ctrl #(.NUM_ROWS(3), .NUM_ROWS_WIDTH(2), .NUM_COLS(8)) dut3 (
        .clk(clk), .i_rst(i_rst), .i_wr_en(b_wr_en), .i_wr_row(b_wr_row),
        .i_wr_data(b_wr_data), .i_commit(b_commit), .i_clear(b_clear),
        .i_frame_end(b_frame_end), .o_frame(b_frame), .o_busy(b_busy),
        .o_swap(b_swap), .o_err(b_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: two banks plus front select.
    logic [7:0]  mbank [0:1][0:3];
    logic        mfront;
    logic [31:0] sb_q [$];
    logic [31:0] sb_exp;

    function automatic logic [31:0] dut_frame();
        return {o_frame[3], o_frame[2], o_frame[1], o_frame[0]};
    endfunction

    function automatic logic [31:0] model_front();
        return {mbank[mfront][3], mbank[mfront][2], mbank[mfront][1], mbank[mfront][0]};
    endfunction

    function automatic logic [31:0] model_back();
        logic b;
        b = ~mfront;
        return {mbank[b][3], mbank[b][2], mbank[b][1], mbank[b][0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_wr_en = 0; i_wr_row = '0; i_wr_data = '0;
        i_commit = 0; i_clear = 0; i_frame_end = 0;
        b_wr_en = 0; b_wr_row = '0; b_wr_data = '0;
        b_commit = 0; b_clear = 0; b_frame_end = 0;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++)
                mbank[b][r] = '0;
        mfront = 1'b0;
    endtask

    task automatic model_write(input int r, input logic [7:0] d);
        mbank[~mfront][r] = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1'b1;
        model_reset();
        repeat (2) tick();
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_swap !== 1'b0) begin n_errors++; $display("FAIL reset_swap: got %b expected 0", o_swap); end
        n_checks++; if (o_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
        n_checks++; if (dut_frame() !== 32'h0) begin n_errors++; $display("FAIL reset_frame: got %h expected 00000000", dut_frame()); end
        #2 i_rst = 1'b0;
        tick();
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_invalid_row();
        b_wr_en = 1; b_wr_row = 2'd3; b_wr_data = 8'hC3;
        tick();
        b_wr_en = 0;
        n_checks++; if (b_err !== 1'b1) begin n_errors++; $display("FAIL bad_row_err: got %b expected 1", b_err); end
        b_wr_en = 1; b_wr_row = 2'd2; b_wr_data = 8'hAB;
        tick();
        b_wr_en = 0;
        n_checks++; if (b_err !== 1'b0) begin n_errors++; $display("FAIL good_row_err: got %b expected 0", b_err); end
        b_commit = 1;
        tick();
        b_commit = 0;
        n_checks++; if (b_busy !== 1'b1) begin n_errors++; $display("FAIL r3_busy: got %b expected 1", b_busy); end
        b_frame_end = 1;
        tick();
        b_frame_end = 0;
        n_checks++; if (b_swap !== 1'b1) begin n_errors++; $display("FAIL r3_swap: got %b expected 1", b_swap); end
        n_checks++;
        if ({b_frame[2], b_frame[1], b_frame[0]} !== 24'hAB0000) begin
            n_errors++;
            $display("FAIL r3_frame: got %h expected ab0000", {b_frame[2], b_frame[1], b_frame[0]});
        end
    endtask

    task automatic test_write_commit();
        logic [7:0] v [0:3];
        int early;
        v = '{8'h11, 8'h22, 8'h44, 8'h88};
        for (int r = 0; r < 4; r++) begin
            i_wr_en = 1; i_wr_row = 2'(r); i_wr_data = v[r];
            tick();
            model_write(r, v[r]);
            n_checks++; if (o_err !== 1'b0) begin n_errors++; $display("FAIL wr_err row%0d: got %b expected 0", r, o_err); end
        end
        i_wr_en = 0;
        n_checks++; if (dut_frame() !== model_front()) begin n_errors++; $display("FAIL front_untouched: got %h expected %h", dut_frame(), model_front()); end
        i_commit = 1;
        tick();
        i_commit = 0;
        sb_q.push_back(model_back());
        n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL pending_busy: got %b expected 1", o_busy); end
        early = 0;
        repeat (5) begin
            tick();
            if (o_swap !== 1'b0 || dut_frame() !== model_front()) early++;
        end
        n_checks++; if (early !== 0) begin n_errors++; $display("FAIL early_swap: got %0d cycles expected 0", early); end
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        n_checks++; if (o_swap !== 1'b1) begin n_errors++; $display("FAIL swap1_pulse: got %b expected 1", o_swap); end
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL swap1_frame: scoreboard empty"); end
        else begin
            sb_exp = sb_q.pop_front();
            if (dut_frame() !== sb_exp) begin n_errors++; $display("FAIL swap1_frame: got %h expected %h", dut_frame(), sb_exp); end
        end
        mfront = ~mfront;
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL swap1_busy: got %b expected 0", o_busy); end
        tick();
        n_checks++; if (o_swap !== 1'b0) begin n_errors++; $display("FAIL swap1_single: got %b expected 0", o_swap); end
    endtask

    task automatic test_commit_with_frame_end();
        int early;
        for (int r = 0; r < 4; r++) begin
            i_wr_en = 1; i_wr_row = 2'(r); i_wr_data = 8'(r + 1);
            tick();
            model_write(r, 8'(r + 1));
        end
        i_wr_en = 0;
        i_commit = 1; i_frame_end = 1;
        tick();
        i_commit = 0; i_frame_end = 0;
        sb_q.push_back(model_back());
        n_checks++; if (o_swap !== 1'b0) begin n_errors++; $display("FAIL same_cycle_swap: got %b expected 0", o_swap); end
        n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL same_cycle_busy: got %b expected 1", o_busy); end
        early = 0;
        repeat (9) begin
            tick();
            if (o_swap !== 1'b0 || o_busy !== 1'b1) early++;
        end
        n_checks++; if (early !== 0) begin n_errors++; $display("FAIL same_cycle_wait: got %0d bad cycles expected 0", early); end
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        n_checks++; if (o_swap !== 1'b1) begin n_errors++; $display("FAIL swap2_pulse: got %b expected 1", o_swap); end
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL swap2_frame: scoreboard empty"); end
        else begin
            sb_exp = sb_q.pop_front();
            if (dut_frame() !== sb_exp) begin n_errors++; $display("FAIL swap2_frame: got %h expected %h", dut_frame(), sb_exp); end
        end
        mfront = ~mfront;
    endtask

    task automatic test_pending_write();
        i_wr_en = 1; i_wr_row = 2'd3; i_wr_data = 8'h5A; i_commit = 1;
        tick();
        i_wr_en = 0; i_commit = 0;
        model_write(3, 8'h5A);
        sb_q.push_back(model_back());
        n_checks++; if (o_err !== 1'b0) begin n_errors++; $display("FAIL commit_wr_err: got %b expected 0", o_err); end
        i_wr_en = 1; i_wr_row = 2'd2; i_wr_data = 8'hEE;
        tick();
        i_wr_en = 0;
        n_checks++; if (o_err !== 1'b1) begin n_errors++; $display("FAIL pending_wr_err: got %b expected 1", o_err); end
        tick();
        n_checks++; if (o_err !== 1'b0) begin n_errors++; $display("FAIL pending_err_width: got %b expected 0", o_err); end
        n_checks++; if (dut_frame() !== model_front()) begin n_errors++; $display("FAIL pending_front: got %h expected %h", dut_frame(), model_front()); end
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        n_checks++; if (o_swap !== 1'b1) begin n_errors++; $display("FAIL swap3_pulse: got %b expected 1", o_swap); end
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL swap3_frame: scoreboard empty"); end
        else begin
            sb_exp = sb_q.pop_front();
            if (dut_frame() !== sb_exp) begin n_errors++; $display("FAIL swap3_frame: got %h expected %h", dut_frame(), sb_exp); end
        end
        mfront = ~mfront;
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int r = 0; r < 4; r++) begin
            i_wr_en = 1; i_wr_row = 2'(r); i_wr_data = 8'hFF;
            tick();
            model_write(r, 8'hFF);
        end
        i_wr_en = 0;
        i_clear = 1; i_commit = 1;
        tick();
        i_clear = 0; i_commit = 0;
        busy_cycles = (o_busy === 1'b1) ? 1 : 0;
        i_wr_en = 1; i_wr_row = 2'd0; i_wr_data = 8'h77;
        tick();
        i_wr_en = 0;
        n_checks++; if (o_err !== 1'b1) begin n_errors++; $display("FAIL clearing_wr_err: got %b expected 1", o_err); end
        if (o_busy === 1'b1) busy_cycles++;
        for (int c = 0; c < 16 && o_busy === 1'b1; c++) begin
            tick();
            if (o_busy === 1'b1) busy_cycles++;
        end
        n_checks++; if (busy_cycles !== 4) begin n_errors++; $display("FAIL clear_busy_len: got %0d expected 4", busy_cycles); end
        for (int r = 0; r < 4; r++) model_write(r, 8'h00);
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        n_checks++; if (o_swap !== 1'b0) begin n_errors++; $display("FAIL clear_commit_ignored: got %b expected 0", o_swap); end
        n_checks++; if (dut_frame() !== model_front()) begin n_errors++; $display("FAIL clear_front: got %h expected %h", dut_frame(), model_front()); end
        i_commit = 1;
        tick();
        i_commit = 0;
        sb_q.push_back(model_back());
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        n_checks++; if (o_swap !== 1'b1) begin n_errors++; $display("FAIL swap4_pulse: got %b expected 1", o_swap); end
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL swap4_frame: scoreboard empty"); end
        else begin
            sb_exp = sb_q.pop_front();
            if (dut_frame() !== sb_exp) begin n_errors++; $display("FAIL swap4_frame: got %h expected %h", dut_frame(), sb_exp); end
        end
        mfront = ~mfront;
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_front;
        first_front = model_front();
        for (int k = 0; k < 2; k++) begin
            i_commit = 1;
            tick();
            i_commit = 0;
            sb_q.push_back(model_back());
            i_frame_end = 1;
            tick();
            i_frame_end = 0;
            n_checks++; if (o_swap !== 1'b1) begin n_errors++; $display("FAIL b2b_pulse%0d: got %b expected 1", k, o_swap); end
            n_checks++;
            if (sb_q.size() == 0) begin n_errors++; $display("FAIL b2b_frame%0d: scoreboard empty", k); end
            else begin
                sb_exp = sb_q.pop_front();
                if (dut_frame() !== sb_exp) begin n_errors++; $display("FAIL b2b_frame%0d: got %h expected %h", k, dut_frame(), sb_exp); end
            end
            mfront = ~mfront;
        end
        n_checks++; if (dut_frame() !== first_front) begin n_errors++; $display("FAIL b2b_alternate: got %h expected %h", dut_frame(), first_front); end
    endtask

    task automatic test_reset_mid_clear();
        // Bring a non-zero frame to the front so the reset is visible.
        i_commit = 1;
        tick();
        i_commit = 0;
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        mfront = ~mfront;
        n_checks++; if (dut_frame() !== model_front()) begin n_errors++; $display("FAIL pre_reset_front: got %h expected %h", dut_frame(), model_front()); end
        i_clear = 1;
        tick();
        i_clear = 0;
        repeat (2) tick();
        #2 i_rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (dut_frame() !== 32'h0) begin n_errors++; $display("FAIL async_rst_frame: got %h expected 00000000", dut_frame()); end
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL async_rst_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_swap !== 1'b0 || o_err !== 1'b0) begin n_errors++; $display("FAIL async_rst_pulses: got %b%b expected 00", o_swap, o_err); end
        @(posedge clk);
        #2 i_rst = 1'b0;
        tick();
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rst_release_busy: got %b expected 0", o_busy); end
        i_wr_en = 1; i_wr_row = 2'd0; i_wr_data = 8'h3C; i_commit = 1;
        tick();
        i_wr_en = 0; i_commit = 0;
        model_write(0, 8'h3C);
        sb_q.push_back(model_back());
        n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL post_rst_busy: got %b expected 1", o_busy); end
        i_frame_end = 1;
        tick();
        i_frame_end = 0;
        n_checks++; if (o_swap !== 1'b1) begin n_errors++; $display("FAIL post_rst_swap: got %b expected 1", o_swap); end
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL post_rst_frame: scoreboard empty"); end
        else begin
            sb_exp = sb_q.pop_front();
            if (dut_frame() !== sb_exp) begin n_errors++; $display("FAIL post_rst_frame: got %h expected %h", dut_frame(), sb_exp); end
        end
        mfront = ~mfront;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_invalid_row();
        test_write_commit();
        test_commit_with_frame_end();
        test_pending_write();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
